gama_therm_encoder: RTL and testbench

- Inverse of the Gama 3-to-6 element decoder. Accepts a 6-bit thermometer word from the DAC element side. The word is filled MSB-first: 100000 means count 1 and 111111 means count 6.
- Returns the 3-bit Gama number through a 2-stage valid/ready pipeline.
- Corrects single bubbles, flags non-thermometer words and counts them in a saturating error counter.
- Used for element-state readback and loopback self-test of the DAC digital path.

---
 rtl/gama_pkg.sv | 44 ++++
 rtl/gama_bubble_fix.sv | 26 ++
 rtl/gama_therm_encoder.sv | 105 ++++++++++
 tb/tb_gama_therm_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gama_pkg.sv
// gama_pkg: definitions shared by the Gama element encoder and decoder.
//   GAMA_W / ELEM_N  - width of a Gama number and number of DAC elements
//   THERM_*          - the seven legal thermometer codes (filled MSB-first)
//   gama_is_legal    - 1 when a word is one of the seven legal codes
//   gama_popcount    - number of set elements, clamped to the largest Gama number
package gama_pkg;

    localparam int GAMA_W = 3;
    localparam int ELEM_N = 6;

    localparam logic [GAMA_W-1:0] GAMA_MAX = 3'd6;

    localparam logic [ELEM_N-1:0] THERM_0 = 6'b000000;
    localparam logic [ELEM_N-1:0] THERM_1 = 6'b100000;
    localparam logic [ELEM_N-1:0] THERM_2 = 6'b110000;
    localparam logic [ELEM_N-1:0] THERM_3 = 6'b111000;
    localparam logic [ELEM_N-1:0] THERM_4 = 6'b111100;
    localparam logic [ELEM_N-1:0] THERM_5 = 6'b111110;
    localparam logic [ELEM_N-1:0] THERM_6 = 6'b111111;

    function automatic logic gama_is_legal(input logic [ELEM_N-1:0] therm);
        logic legal;
        case (therm)
            THERM_0, THERM_1, THERM_2, THERM_3,
            THERM_4, THERM_5, THERM_6: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [GAMA_W-1:0] gama_popcount(input logic [ELEM_N-1:0] therm);
        logic [GAMA_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ELEM_N; i++) begin
            cnt = cnt + GAMA_W'(therm[i]);
        end
        // Keeps the 7 code out of reach even if ELEM_N is ever widened.
        if (cnt > GAMA_MAX) begin
            cnt = GAMA_MAX;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gama_bubble_fix.sv
// gama_bubble_fix: combinational 3-tap majority filter over a thermometer word.
//   therm - raw element word, bit ELEM_N-1 is the first element
//   fixed - filtered word; each bit is the majority of itself and its neighbours
// The word is padded with a 1 above the first element and a 0 below the last,
// so a single missing or stray element is absorbed into the fill level.
module gama_bubble_fix
    import gama_pkg::*;
(
    input  logic [ELEM_N-1:0] therm,
    output logic [ELEM_N-1:0] fixed
);

    // ext[j+1] holds therm[j]; ext[ELEM_N+1] = 1 and ext[0] = 0 are the pads.
    logic [ELEM_N+1:0] ext;
    assign ext = {1'b1, therm, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < ELEM_N; gi++) begin : g_maj
            assign fixed[gi] = (ext[gi+2] & ext[gi+1]) |
                               (ext[gi+2] & ext[gi])   |
                               (ext[gi+1] & ext[gi]);
        end
    endgenerate

endmodule

// File: rtl/gama_therm_encoder.sv
// gama_therm_encoder: 6-element thermometer word -> 3-bit Gama number.
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   therm_in, in_valid,
//   in_ready            - input word handshake
//   s_out, out_err,
//   out_valid, out_ready - output handshake; out_err marks an illegal word
//   clr_err             - synchronous clear of err_cnt (wins over an increment)
//   err_cnt             - saturating count of illegal words loaded into stage 2
// Stage 1 captures the raw word, stage 2 encodes it and holds the result.
module gama_therm_encoder
    import gama_pkg::*;
#(
    parameter int ERR_CNT_W  = 8,
    parameter int BUBBLE_FIX = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ELEM_N-1:0]    therm_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [GAMA_W-1:0]    s_out,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic                 v1_reg;
    logic                 v2_reg;
    logic [ELEM_N-1:0]    r1_reg;
    logic [GAMA_W-1:0]    s_out_reg;
    logic                 out_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    logic              advance;
    logic              load2;
    logic              word_legal;
    logic [ELEM_N-1:0] enc_word;
    logic [GAMA_W-1:0] code;

    // Stage 2 can take a new word when empty or when its word leaves this edge.
    assign advance  = !v2_reg || out_ready;
    assign load2    = advance && v1_reg;
    assign in_ready = !v1_reg || advance;

    // Legality is judged on the raw word, before any correction.
    assign word_legal = gama_is_legal(r1_reg);

    generate
        if (BUBBLE_FIX != 0) begin : g_fix
            gama_bubble_fix u_fix (
                .therm (r1_reg),
                .fixed (enc_word)
            );
        end else begin : g_raw
            assign enc_word = r1_reg;
        end
    endgenerate

    assign code = gama_popcount(enc_word);

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (clr_err) begin
            err_cnt_next = '0;
        end else if (load2 && !word_legal && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            r1_reg      <= '0;
            s_out_reg   <= '0;
            out_err_reg <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            if (advance) begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    s_out_reg   <= code;
                    out_err_reg <= !word_legal;
                end
            end
            // Stage 1 refills whenever it is empty or draining into stage 2.
            if (in_ready) begin
                v1_reg <= in_valid;
                if (in_valid) begin
                    r1_reg <= therm_in;
                end
            end
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign s_out     = s_out_reg;
    assign out_err   = out_err_reg;
    assign out_valid = v2_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_gama_therm_encoder.sv
module tb_gama_therm_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] therm_in;
    logic       in_valid;
    logic       in_ready, in_ready_raw;
    logic [2:0] s_out, s_out_raw;
    logic       out_err, out_err_raw;
    logic       out_valid, out_valid_raw;
    logic       out_ready;
    logic       clr_err;
    logic [7:0] err_cnt, err_cnt_raw;

    always #5 clk = ~clk;

    gama_therm_encoder #(.ERR_CNT_W(8), .BUBBLE_FIX(1)) dut (
        .clk(clk), .rst(rst), .therm_in(therm_in), .in_valid(in_valid),
        .in_ready(in_ready), .s_out(s_out), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready), .clr_err(clr_err),
        .err_cnt(err_cnt)
    );

    gama_therm_encoder #(.ERR_CNT_W(8), .BUBBLE_FIX(0)) dut_raw (
        .clk(clk), .rst(rst), .therm_in(therm_in), .in_valid(in_valid),
        .in_ready(in_ready_raw), .s_out(s_out_raw), .out_err(out_err_raw),
        .out_valid(out_valid_raw), .out_ready(out_ready), .clr_err(clr_err),
        .err_cnt(err_cnt_raw)
    );

    typedef struct packed {
        logic [5:0] word;
        logic [2:0] s_fix;
        logic [2:0] s_raw;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_acc = -1;
    int   first_out = -1;
    int   rst_events = 0;
    int   hold_rst_snap = 0;
    logic held = 1'b0;
    logic [2:0] hold_s;
    logic       hold_e;
    exp_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst) rst_events <= rst_events + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every delivery and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held && (hold_rst_snap == rst_events)) begin
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_s_out", 32'(s_out), 32'(hold_s));
                chk("hold_out_err", 32'(out_err), 32'(hold_e));
            end
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                if (out_ready) begin
                    chk("raw_out_valid_align", 32'(out_valid_raw), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got s_out=%0d, required no output", s_out);
                    end else begin
                        mon_e = exp_q.pop_front();
                        $display("out word=%b s_out=%0d out_err=%0d s_raw=%0d (exp %0d/%0d/%0d)",
                                 mon_e.word, s_out, out_err, s_out_raw,
                                 mon_e.s_fix, mon_e.err, mon_e.s_raw);
                        chk("s_out_fix", 32'(s_out), 32'(mon_e.s_fix));
                        chk("out_err", 32'(out_err), 32'(mon_e.err));
                        chk("s_out_raw", 32'(s_out_raw), 32'(mon_e.s_raw));
                    end
                end
            end
            held          = out_valid && !out_ready;
            hold_s        = s_out;
            hold_e        = out_err;
            hold_rst_snap = rst_events;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [5:0] w, input logic [2:0] sf,
                        input logic [2:0] sr, input logic e);
        int   n = 0;
        exp_t x;
        therm_in = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %b not accepted, in_ready=%0d required 1", w, in_ready);
            in_valid = 1'b0;
            return;
        end
        x.word  = w;
        x.s_fix = sf;
        x.s_raw = sr;
        x.err   = e;
        exp_q.push_back(x);
        if (first_acc < 0) first_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] legal_w [7];

    initial begin
        legal_w = '{6'b000000, 6'b100000, 6'b110000, 6'b111000,
                    6'b111100, 6'b111110, 6'b111111};
        rst       = 1'b1;
        therm_in  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_s_out", 32'(s_out), 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // Legal sweep, back to back.
        for (int i = 0; i < 7; i++) begin
            send(legal_w[i], 3'(i), 3'(i), 1'b0);
        end
        drain();
        chk("latency_cycles", 32'(first_out - first_acc), 32'd2);
        chk("legal_err_cnt", 32'(err_cnt), 32'd0);

        // Bubble correction.
        send(6'b110100, 3'd3, 3'd3, 1'b1);
        send(6'b101000, 3'd2, 3'd2, 1'b1);
        send(6'b011111, 3'd6, 3'd5, 1'b1);
        drain();
        chk("bubble_err_cnt", 32'(err_cnt), 32'd3);
        chk("bubble_err_cnt_raw", 32'(err_cnt_raw), 32'd3);

        // Backpressure while streaming 3,4,5.
        out_ready = 1'b0;
        fork
            begin
                send(6'b111000, 3'd3, 3'd3, 1'b0);
                send(6'b111100, 3'd4, 3'd4, 1'b0);
                send(6'b111110, 3'd5, 3'd5, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_s_out", 32'(s_out), 32'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            send(6'b010101, 3'd3, 3'd3, 1'b1);
        end
        drain();
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Clear, then clear colliding with an illegal load.
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        send(6'b010101, 3'd3, 3'd3, 1'b1);
        @(posedge clk);
        #1;
        chk("inc_after_clr", 32'(err_cnt), 32'd1);
        send(6'b010101, 3'd3, 3'd3, 1'b1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_beats_inc", 32'(err_cnt), 32'd0);
        send(6'b101000, 3'd2, 3'd2, 1'b1);
        @(posedge clk);
        #1;
        chk("inc_after_collision", 32'(err_cnt), 32'd1);
        drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(6'b111000, 3'd3, 3'd3, 1'b0);
        send(6'b111100, 3'd4, 3'd4, 1'b0);
        #1;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6'b111100, 3'd4, 3'd4, 1'b0);
        drain();
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
